apb_uart_csr: RTL
=================

APB_UART_CSR -- requirements
Module: apb_uart_csr

Interface
REQ-001 SHALL have parameter DATA_W, default 8, UART character width, legal range 5..9.
REQ-002 SHALL have parameter TX_DEPTH, default 16, TX FIFO entries, power of two, minimum 2.
REQ-003 SHALL have parameter RX_DEPTH, default 16, RX FIFO entries, power of two, minimum 2.
REQ-004 SHALL have port PCLK, input, 1 bit, the single clock.
REQ-005 SHALL have port PRESET, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have APB inputs PSEL, PENABLE and PWRITE (1 bit each), PADDR (8 bits, byte offset) and PWDATA (32 bits).
REQ-007 SHALL have APB outputs PRDATA (32 bits), PREADY (1 bit) and PSLVERR (1 bit).
REQ-008 SHALL have port ctrl_reg, output, 4 bits, UART control bits.
REQ-009 SHALL have TX side ports tx_data (output, DATA_W), tx_valid (output, 1) and tx_ready (input, 1, core accepts a character).
REQ-010 SHALL have RX side ports rx_data (input, DATA_W), rx_valid (input, 1, one-cycle character strobe) and rx_error (input, 1, framing error, qualified by rx_valid).
REQ-011 SHALL have status inputs tx_busy and rx_busy, 1 bit each.
REQ-012 SHALL have port irq, output, 1 bit, level interrupt, present only with APB_UART_CSR_IRQ_EN.

Function
REQ-013 SHALL use this register map: 0x00 CTRL RW [3:0]; 0x04 STAT; 0x08 TXDATA WO; 0x0C RXDATA RO; 0x10 LEVEL RO; 0x14 IRQ_EN RW; 0x18 IRQ_STAT W1C.
REQ-014 SHALL lay out STAT as {rx_busy, tx_busy, rx_ovf, rx_ferr, rx_full, rx_empty, tx_full, tx_empty} in bits [7:0], with bits [5:4] write-1-to-clear and all other bits read-only.
REQ-015 SHALL drive PREADY=1 during every access phase (PSEL&PENABLE), giving zero wait states; all side effects occur on that single access cycle.
REQ-016 SHALL drive PRDATA combinationally from PADDR, zero-extended, and SHALL drive 0 outside an access phase.
REQ-017 SHALL assert PSLVERR in the access cycle for: an unmapped offset, a misaligned offset (PADDR[1:0]!=0), a write to 0x0C or 0x10, a read of 0x08, a TXDATA write when the TX FIFO is full, or an RXDATA read when the RX FIFO is empty.
REQ-018 SHALL produce no register or FIFO side effect on any access that asserts PSLVERR.
REQ-019 SHALL push PWDATA[DATA_W-1:0] into the TX FIFO on a TXDATA write; a write while full is an error even if a pop occurs in the same cycle.
REQ-020 SHALL drive tx_valid = !tx_empty and tx_data = the TX FIFO head, and SHALL pop the head on tx_valid&tx_ready.
REQ-021 SHALL push rx_data into the RX FIFO on rx_valid; if the FIFO is full and no pop occurs that cycle, the character is dropped and rx_ovf is set (sticky).
REQ-022 SHALL push and pop the RX FIFO in the same cycle when full, with rx_valid and an RXDATA read together: the oldest entry is returned, the new entry is stored, and rx_ovf is not set.
REQ-023 SHALL set rx_ferr (sticky) on rx_valid&rx_error, and SHALL still push that character.
REQ-024 SHALL give a hardware set priority over a same-cycle W1C clear on any sticky bit.
REQ-025 SHALL return RXDATA as the head entry and pop it in the same access cycle.
REQ-026 SHALL lay out LEVEL as tx_count in [7:0] and rx_count in [15:8]; counts are $clog2(DEPTH)+1 bits wide, range 0..DEPTH, wrap-free, with pointers wrapping modulo DEPTH.
REQ-027 SHALL define IRQ_STAT sources as bit0 tx_empty (level), bit1 rx_count>=1 (level), bit2 rx_ovf and bit3 rx_ferr, and SHALL drive irq = |(IRQ_STAT & IRQ_EN[3:0]) as a registered output with one cycle of latency.

Reset
REQ-028 SHALL, while PRESET is high (asynchronous), clear CTRL, IRQ_EN, all sticky bits, FIFO pointers and counts, tx_valid and irq, and SHALL discard FIFO contents.
REQ-029 SHALL discard a transfer in flight when reset occurs mid-access; after release it SHALL report tx_empty=rx_empty=1 and LEVEL=0.

Configuration
REQ-030 SHALL include, when APB_UART_CSR_IRQ_EN is defined, the IRQ_EN and IRQ_STAT registers and the irq port.
REQ-031 SHALL, when APB_UART_CSR_IRQ_EN is undefined, omit the irq port and treat 0x14 and 0x18 as unmapped (PSLVERR=1).

Structure
REQ-032 SHALL place the register offsets, STAT bit indices and IRQ bit indices in package apb_uart_pkg.
REQ-033 SHALL implement each FIFO as an instance of sub-module apb_uart_fifo (parameters WIDTH and DEPTH; ports push, pop, wdata, rdata, full, empty and count), instantiated twice.

Verification
REQ-034 SHALL cover: write CTRL=0xA, then read 0x00 -> PRDATA=0xA, PSLVERR=0.
REQ-035 SHALL cover: with tx_ready=0, 16 TXDATA writes then a 17th -> first 16 give PSLVERR=0, LEVEL[7:0]=16; the 17th gives PSLVERR=1 with no change.
REQ-036 SHALL cover: drive 17 rx_valid strobes (0x01..0x11) with no reads -> rx_ovf=1, rx_count=16, and reads return 0x01..0x10 followed by PSLVERR=1 on the empty read.
REQ-037 SHALL cover: with RX full, an RXDATA read and an rx_valid of 0x55 in the same cycle -> the read returns the oldest entry, count stays 16, rx_ovf=0.
REQ-038 SHALL cover: with APB_UART_CSR_IRQ_EN, IRQ_EN=0x4 and an overflow -> irq=1 the next cycle; writing 0x4 to IRQ_STAT -> irq=0.
REQ-039 SHALL cover: assert PRESET mid-access with 5 TX entries queued -> tx_valid=0 immediately and LEVEL=0 after release.

Source files
------------

// File: rtl/apb_uart_pkg.sv
// Shared register offsets and bit positions for the APB UART control/status block.
package apb_uart_pkg;

    localparam logic [7:0] OFF_CTRL     = 8'h00;
    localparam logic [7:0] OFF_STAT     = 8'h04;
    localparam logic [7:0] OFF_TXDATA   = 8'h08;
    localparam logic [7:0] OFF_RXDATA   = 8'h0C;
    localparam logic [7:0] OFF_LEVEL    = 8'h10;
    localparam logic [7:0] OFF_IRQ_EN   = 8'h14;
    localparam logic [7:0] OFF_IRQ_STAT = 8'h18;

    localparam int STAT_TX_EMPTY = 0;
    localparam int STAT_TX_FULL  = 1;
    localparam int STAT_RX_EMPTY = 2;
    localparam int STAT_RX_FULL  = 3;
    localparam int STAT_RX_FERR  = 4;
    localparam int STAT_RX_OVF   = 5;
    localparam int STAT_TX_BUSY  = 6;
    localparam int STAT_RX_BUSY  = 7;

    localparam int IRQ_TX_EMPTY = 0;
    localparam int IRQ_RX_AVAIL = 1;
    localparam int IRQ_RX_OVF   = 2;
    localparam int IRQ_RX_FERR  = 3;

endpackage

// File: rtl/apb_uart_fifo.sv
// Synchronous FIFO with occupancy count; the caller guarantees push only when
// not full (or popping in the same cycle) and pop only when not empty.
module apb_uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;

    // Storage array; stale contents are unreachable once pointers reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers wrap modulo DEPTH; the count spans 0..DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == CW'(0));
    assign count = count_r;

endmodule

// File: rtl/apb_uart_csr.sv
// APB register front-end for a UART core: CTRL/STAT, TX/RX FIFOs, levels.
// Interrupt registers and the irq port exist only with APB_UART_CSR_IRQ_EN.
module apb_uart_csr
    import apb_uart_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [7:0]        PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [3:0]        ctrl_reg,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              rx_error,
    input  logic              tx_busy,
    input  logic              rx_busy
`ifdef APB_UART_CSR_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int TXCW = $clog2(TX_DEPTH) + 1;
    localparam int RXCW = $clog2(RX_DEPTH) + 1;

    logic              access_s, err_s, ok_wr_s, ok_rd_s;
    logic              tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
    logic              tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
    logic [DATA_W-1:0] rx_head_s;
    logic [TXCW-1:0]   tx_count_s;
    logic [RXCW-1:0]   rx_count_s;
    logic [3:0]        ctrl_r;
    logic              ovf_r, ferr_r;
    logic              ovf_set_s, ferr_set_s, ovf_clr_s, ferr_clr_s;
    logic [7:0]        stat_s;
    logic [31:0]       prdata_s;
    logic              unused_s;

    assign access_s = PSEL & PENABLE;

    // Error decode; misaligned offsets never match a case item.
    always_comb begin
        err_s = 1'b0;
        if (access_s) begin
            case (PADDR)
                OFF_CTRL, OFF_STAT: err_s = 1'b0;
                OFF_TXDATA:         err_s = !PWRITE | tx_full_s;
                OFF_RXDATA:         err_s = PWRITE | rx_empty_s;
                OFF_LEVEL:          err_s = PWRITE;
`ifdef APB_UART_CSR_IRQ_EN
                OFF_IRQ_EN, OFF_IRQ_STAT: err_s = 1'b0;
`endif
                default:            err_s = 1'b1;
            endcase
        end else begin
            err_s = 1'b0;
        end
    end

    assign ok_wr_s   = access_s & PWRITE & !err_s;
    assign ok_rd_s   = access_s & !PWRITE & !err_s;
    assign tx_push_s = ok_wr_s & (PADDR == OFF_TXDATA);
    assign tx_pop_s  = !tx_empty_s & tx_ready;
    assign rx_pop_s  = ok_rd_s & (PADDR == OFF_RXDATA);
    // A full RX FIFO still accepts a character when a read frees a slot.
    assign rx_push_s  = rx_valid & (!rx_full_s | rx_pop_s);
    assign ovf_set_s  = rx_valid & rx_full_s & !rx_pop_s;
    assign ferr_set_s = rx_valid & rx_error;

    // Sticky-bit clear requests from STAT or IRQ_STAT writes.
    always_comb begin
        ovf_clr_s  = 1'b0;
        ferr_clr_s = 1'b0;
        if (ok_wr_s && (PADDR == OFF_STAT)) begin
            ovf_clr_s  = PWDATA[STAT_RX_OVF];
            ferr_clr_s = PWDATA[STAT_RX_FERR];
        end
`ifdef APB_UART_CSR_IRQ_EN
        else if (ok_wr_s && (PADDR == OFF_IRQ_STAT)) begin
            ovf_clr_s  = PWDATA[IRQ_RX_OVF];
            ferr_clr_s = PWDATA[IRQ_RX_FERR];
        end
`endif
        else begin
            ovf_clr_s  = 1'b0;
            ferr_clr_s = 1'b0;
        end
    end

    // CTRL and sticky status; a hardware set wins over a same-cycle clear.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ctrl_r <= 4'd0;
            ovf_r  <= 1'b0;
            ferr_r <= 1'b0;
        end else begin
            if (ok_wr_s && (PADDR == OFF_CTRL)) begin
                ctrl_r <= PWDATA[3:0];
            end
            ovf_r  <= ovf_set_s | (ovf_r & !ovf_clr_s);
            ferr_r <= ferr_set_s | (ferr_r & !ferr_clr_s);
        end
    end

    // STAT assembly.
    always_comb begin
        stat_s                = 8'd0;
        stat_s[STAT_TX_EMPTY] = tx_empty_s;
        stat_s[STAT_TX_FULL]  = tx_full_s;
        stat_s[STAT_RX_EMPTY] = rx_empty_s;
        stat_s[STAT_RX_FULL]  = rx_full_s;
        stat_s[STAT_RX_FERR]  = ferr_r;
        stat_s[STAT_RX_OVF]   = ovf_r;
        stat_s[STAT_TX_BUSY]  = tx_busy;
        stat_s[STAT_RX_BUSY]  = rx_busy;
    end

`ifdef APB_UART_CSR_IRQ_EN
    logic [3:0] irq_en_r;
    logic [3:0] irq_stat_s;
    logic       irq_r;

    assign irq_stat_s = {ferr_r, ovf_r, !rx_empty_s, tx_empty_s};

    // Interrupt enable register and registered interrupt line.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            irq_en_r <= 4'd0;
            irq_r    <= 1'b0;
        end else begin
            if (ok_wr_s && (PADDR == OFF_IRQ_EN)) begin
                irq_en_r <= PWDATA[3:0];
            end
            irq_r <= |(irq_stat_s & irq_en_r);
        end
    end

    assign irq = irq_r;
`endif

    // Read data mux, zero outside a successful read access.
    always_comb begin
        prdata_s = 32'd0;
        if (ok_rd_s) begin
            case (PADDR)
                OFF_CTRL:     prdata_s = {28'd0, ctrl_r};
                OFF_STAT:     prdata_s = {24'd0, stat_s};
                OFF_RXDATA:   prdata_s = {{(32-DATA_W){1'b0}}, rx_head_s};
                OFF_LEVEL:    prdata_s = {16'd0, 8'(rx_count_s), 8'(tx_count_s)};
`ifdef APB_UART_CSR_IRQ_EN
                OFF_IRQ_EN:   prdata_s = {28'd0, irq_en_r};
                OFF_IRQ_STAT: prdata_s = {28'd0, irq_stat_s};
`endif
                default:      prdata_s = 32'd0;
            endcase
        end else begin
            prdata_s = 32'd0;
        end
    end

    apb_uart_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (PCLK),
        .rst   (PRESET),
        .push  (tx_push_s),
        .pop   (tx_pop_s),
        .wdata (PWDATA[DATA_W-1:0]),
        .rdata (tx_data),
        .full  (tx_full_s),
        .empty (tx_empty_s),
        .count (tx_count_s)
    );

    apb_uart_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (PCLK),
        .rst   (PRESET),
        .push  (rx_push_s),
        .pop   (rx_pop_s),
        .wdata (rx_data),
        .rdata (rx_head_s),
        .full  (rx_full_s),
        .empty (rx_empty_s),
        .count (rx_count_s)
    );

    assign PRDATA   = prdata_s;
    assign PREADY   = access_s;
    assign PSLVERR  = err_s;
    assign ctrl_reg = ctrl_r;
    assign tx_valid = !tx_empty_s;
    assign unused_s = &{1'b0, PWDATA};

endmodule
